// File: rtl/lsu_ctrl.sv
// Load/store unit controller: RV32I load formatting, word stores and sub-word read-modify-write.
// Optional feature macro: LSU_SUBWORD_EN enables byte/half accesses; otherwise only word accesses are legal.
module lsu_ctrl #(
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        aligned;
  logic        f3_ok;
  logic        legal;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
`ifdef LSU_SUBWORD_EN
    if (is_store)
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
`else
    f3_ok = (funct3 == 3'b010);
`endif
    legal = f3_ok & aligned;
  end

  // Lane shift: bytes use addr[1:0], halves use addr[1]; the same shift serves load and merge.
  always_comb begin
    lane_sh   = f3_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    lane_mask = f3_q[0] ? (32'h0000_FFFF << lane_sh) : (32'h0000_00FF << lane_sh);
    merged    = (mem_rd & ~lane_mask) | ((wd_q << lane_sh) & lane_mask);
    shifted   = mem_rd >> lane_sh;
    case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: load_fmt = mem_rd;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!legal)
            state_nx = RESP;
          else if (is_store && funct3 == 3'b010)
            state_nx = WR;
          else
            state_nx = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nx = RD_WAIT;
`ifdef LSU_SUBWORD_EN
      RD_WAIT:  state_nx = st_q ? WR : RESP;
`else
      RD_WAIT:  state_nx = RESP;
`endif
      WR:       state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    done      = (state == RESP);
    rdata     = (state == RESP) ? rdata_q : '0;
    err       = (state == RESP) & err_q;
    mem_we    = (state == WR);
    mem_wd    = (state == WR) ? wd_q : '0;
    mem_a     = (state == RD_ISSUE || state == RD_WAIT || state == WR) ? {addr_q[31:2], 2'b00} : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        st_q    <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wd_q    <= wdata;
        err_q   <= ~legal;
        rdata_q <= legal ? '0 : ERR_RDATA;
      end else if (state == RD_WAIT) begin
        if (st_q)
          wd_q <= merged;
        else
          rdata_q <= load_fmt;
      end
    end
  end

endmodule
